// File: rtl/flood_reveal_ctrl_pkg.sv
// Shared constants, neighbour offsets and FSM encoding for the flood-fill reveal sequencer.
package flood_reveal_ctrl_pkg;

  localparam int GRID_W = 16;
  localparam int GRID_H = 16;
  localparam int ADDR_W = 8;

  // Neighbour offsets in scan order k=0..7, two's complement (2'b11 = -1).
  // (-1,-1),(0,-1),(+1,-1),(-1,0),(+1,0),(-1,+1),(0,+1),(+1,+1)
  localparam logic [1:0] NB_DX [8] = '{2'b11, 2'b00, 2'b01, 2'b11, 2'b01, 2'b11, 2'b00, 2'b01};
  localparam logic [1:0] NB_DY [8] = '{2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01};

  typedef enum logic [2:0] {
    IDLE,
    SEED_RD,
    SEED_CHK,
    POP,
    NB_RD,
    NB_CHK,
    WR,
    DONE
  } fill_state_t;

endpackage

// File: rtl/flood_reveal_ctrl_cell_fifo.sv
// Synchronous show-ahead FIFO of cell addresses with flush and async reset.
module cell_fifo
  import flood_reveal_ctrl_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic [ADDR_W-1:0] din,
  input  logic              pop,
  output logic [ADDR_W-1:0] dout,
  output logic              empty,
  output logic              full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW:0]       count;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(DEPTH));
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign dout    = mem[rd_ptr];

  // Storage array; no reset needed since empty/count gate every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping; flush returns to empty in one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/flood_reveal_ctrl.sv
// Breadth-first flood-fill reveal sequencer: reveals a seed cell and every
// connected zero-adjacency region plus its numbered border.
// Handshake: rv_wr_req rises with rv_wr_addr stable and both hold until the
// first cycle rv_wr_gnt=1 is sampled; that cycle is the write, and req drops
// on the following cycle.
module flood_reveal_ctrl
  import flood_reveal_ctrl_pkg::*;
#(
  parameter int QDEPTH = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] seed_addr,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [8:0]        cells_revealed,
  output logic [ADDR_W-1:0] q_addr,
  input  logic              q_mine,
  input  logic              q_flag,
  input  logic              q_revealed,
  input  logic [3:0]        q_adj,
  output logic              rv_wr_req,
  input  logic              rv_wr_gnt,
  output logic [ADDR_W-1:0] rv_wr_addr,
  output logic              rv_wr_data
);

  fill_state_t       state;
  fill_state_t       next_state;

  logic [ADDR_W-1:0] q_hold;     // last address actually queried
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] center;
  logic [2:0]        k;
  logic              push_tag;   // queue the pending write's address on grant
  logic              ret_nb;     // pending write came from the neighbour scan

  logic [4:0]        nb_x;
  logic [4:0]        nb_y;
  logic              nb_ok;
  logic [ADDR_W-1:0] nb_addr;
  logic              blocked;
  logic              zero_adj;
  logic              last_k;

  logic              fifo_push;
  logic              fifo_pop;
  logic [ADDR_W-1:0] fifo_dout;
  logic              fifo_empty;
  logic              fifo_full;

  assign blocked    = q_revealed | q_flag | q_mine;
  assign zero_adj   = (q_adj == 4'd0);
  assign last_k     = (k == 3'd7);

  assign busy       = (state != IDLE) && (state != DONE);
  assign done       = (state == DONE);
  assign rv_wr_req  = (state == WR);
  assign rv_wr_addr = wr_addr;
  assign rv_wr_data = 1'b1;

  // Out-of-range neighbours are never presented as a query.
  assign q_addr     = (state == NB_RD && nb_ok) ? nb_addr : q_hold;

  assign fifo_push  = (state == WR) && rv_wr_gnt && push_tag && !abort && !fifo_full;
  assign fifo_pop   = (state == POP) && !fifo_empty && !abort;

  // Neighbour k of the centre cell; an underflow shows up as a large value so
  // a single compare against the grid size catches both edges.
  always_comb begin
    nb_x    = {1'b0, center[3:0]} + {{3{NB_DX[k][1]}}, NB_DX[k]};
    nb_y    = {1'b0, center[7:4]} + {{3{NB_DY[k][1]}}, NB_DY[k]};
    nb_ok   = (nb_x < 5'(GRID_W)) && (nb_y < 5'(GRID_H));
    nb_addr = {nb_y[3:0], nb_x[3:0]};
  end

  // FSM state register; abort wins over everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        state <= IDLE;
    else if (abort) state <= IDLE;
    else            state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (start) next_state = SEED_RD;
      SEED_RD:  next_state = SEED_CHK;
      SEED_CHK: next_state = blocked ? DONE : WR;
      WR: begin
        if (rv_wr_gnt) begin
          if (!ret_nb)     next_state = POP;
          else if (last_k) next_state = POP;
          else             next_state = NB_RD;
        end
      end
      POP:      next_state = fifo_empty ? DONE : NB_RD;
      NB_RD: begin
        if (nb_ok)       next_state = NB_CHK;
        else if (last_k) next_state = POP;
        else             next_state = NB_RD;
      end
      NB_CHK: begin
        if (!blocked)    next_state = WR;
        else if (last_k) next_state = POP;
        else             next_state = NB_RD;
      end
      DONE:     next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Datapath registers: query/write addresses, scan index and reveal counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_hold         <= '0;
      wr_addr        <= '0;
      center         <= '0;
      k              <= '0;
      push_tag       <= 1'b0;
      ret_nb         <= 1'b0;
      cells_revealed <= '0;
    end else if (!abort) begin
      case (state)
        IDLE: begin
          if (start) begin
            q_hold         <= seed_addr;
            cells_revealed <= '0;
          end
        end
        SEED_CHK: begin
          if (!blocked) begin
            wr_addr  <= q_hold;
            push_tag <= zero_adj;
            ret_nb   <= 1'b0;
          end
        end
        WR: begin
          if (rv_wr_gnt) begin
            cells_revealed <= cells_revealed + 9'd1;
            if (ret_nb) k <= k + 3'd1;
          end
        end
        POP: begin
          if (!fifo_empty) begin
            center <= fifo_dout;
            k      <= '0;
          end
        end
        NB_RD: begin
          if (nb_ok) q_hold <= nb_addr;
          else       k      <= k + 3'd1;
        end
        NB_CHK: begin
          if (blocked) begin
            k <= k + 3'd1;
          end else begin
            wr_addr  <= q_hold;
            push_tag <= zero_adj;
            ret_nb   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  cell_fifo #(
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (abort),
    .push  (fifo_push),
    .din   (wr_addr),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

endmodule

// File: tb/tb_flood_reveal_ctrl.sv
// Directed bench for flood_reveal_ctrl with a behavioural board/arbiter model.
module tb_flood_reveal_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] seed_addr;
  logic       abort;
  logic       busy;
  logic       done;
  logic [8:0] cells_revealed;
  logic [7:0] q_addr;
  logic       q_mine;
  logic       q_flag;
  logic       q_revealed;
  logic [3:0] q_adj;
  logic       rv_wr_req;
  logic       gnt;
  logic [7:0] rv_wr_addr;
  logic       rv_wr_data;

  bit         mine    [256];
  bit         flag    [256];
  bit         rev     [256];
  logic [3:0] adj     [256];
  int         wr_count[256];
  bit         queried [256];
  int         total_writes;
  int         done_cnt;
  bit         full_seen;

  int passed = 0;
  int total  = 0;

  flood_reveal_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .seed_addr      (seed_addr),
    .abort          (abort),
    .busy           (busy),
    .done           (done),
    .cells_revealed (cells_revealed),
    .q_addr         (q_addr),
    .q_mine         (q_mine),
    .q_flag         (q_flag),
    .q_revealed     (q_revealed),
    .q_adj          (q_adj),
    .rv_wr_req      (rv_wr_req),
    .rv_wr_gnt      (gnt),
    .rv_wr_addr     (rv_wr_addr),
    .rv_wr_data     (rv_wr_data)
  );

  // Clock.
  always #5 clk = ~clk;

  // Board model: registered query port, reveal writes on req&gnt, event tallies.
  always @(posedge clk) begin
    q_mine     <= mine[q_addr];
    q_flag     <= flag[q_addr];
    q_revealed <= rev[q_addr];
    q_adj      <= adj[q_addr];
    if (busy) queried[q_addr] = 1'b1;
    if (rv_wr_req && gnt && !abort) begin
      rev[rv_wr_addr] = 1'b1;
      wr_count[rv_wr_addr] = wr_count[rv_wr_addr] + 1;
      total_writes = total_writes + 1;
    end
    if (done) done_cnt = done_cnt + 1;
    if (dut.u_fifo.full) full_seen = 1'b1;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic clear_board(input logic [3:0] a);
    for (int i = 0; i < 256; i++) begin
      mine[i] = 1'b0; flag[i] = 1'b0; rev[i] = 1'b0; adj[i] = a;
      wr_count[i] = 0; queried[i] = 1'b0;
    end
    total_writes = 0;
    done_cnt     = 0;
    full_seen    = 1'b0;
  endtask

  task automatic kick(input logic [7:0] s);
    @(negedge clk);
    seed_addr = s;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cycles, output bit timed_out);
    cycles    = 1;
    timed_out = 1'b0;
    while (!done) begin
      if (cycles >= budget) begin
        timed_out = 1'b1;
        break;
      end
      @(negedge clk);
      cycles++;
    end
  endtask

  function automatic int count_once();
    int n = 0;
    for (int i = 0; i < 256; i++) if (wr_count[i] == 1) n++;
    return n;
  endfunction

  function automatic int count_queried();
    int n = 0;
    for (int i = 0; i < 256; i++) if (queried[i]) n++;
    return n;
  endfunction

  initial begin
    int cyc;
    bit to;
    int bad;
    int n;

    rst = 1'b1; start = 1'b0; seed_addr = '0; abort = 1'b0; gnt = 1'b1;
    clear_board(4'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state.
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_req", rv_wr_req, 0);
    chk("rst_wr_addr", rv_wr_addr, 0);
    chk("rst_q_addr", q_addr, 0);
    chk("rst_count", cells_revealed, 0);

    // Open board from corner 0x00: every cell revealed once.
    clear_board(4'd0);
    kick(8'h00);
    wait_done(7000, cyc, to);
    @(negedge clk);
    chk("full_timeout", to, 0);
    chk("full_writes", total_writes, 256);
    chk("full_once", count_once(), 256);
    chk("full_count", cells_revealed, 256);
    chk("full_done_pulses", done_cnt, 1);
    chk("full_fifo_full", full_seen, 0);
    chk("full_data", rv_wr_data, 1);

    // Numbered seed: single write, fast completion, no neighbour queries.
    clear_board(4'd0);
    adj[8'h55] = 4'd3;
    kick(8'h55);
    wait_done(50, cyc, to);
    @(negedge clk);
    chk("num_timeout", to, 0);
    chk("num_latency_le6", (cyc <= 6) ? 1 : 0, 1);
    chk("num_writes", total_writes, 1);
    chk("num_wr_55", wr_count[8'h55], 1);
    chk("num_count", cells_revealed, 1);
    chk("num_queries", count_queried(), 1);

    // Corner 0xFF: no wrap-around to the opposite edges.
    clear_board(4'd1);
    adj[8'hFF] = 4'd0;
    kick(8'hFF);
    wait_done(200, cyc, to);
    @(negedge clk);
    chk("corner_timeout", to, 0);
    chk("corner_writes", total_writes, 4);
    chk("corner_set", wr_count[8'hFF] + wr_count[8'hEE] + wr_count[8'hEF] + wr_count[8'hFE], 4);
    chk("corner_count", cells_revealed, 4);
    chk("corner_q00", queried[8'h00], 0);
    chk("corner_q0f", queried[8'h0F], 0);
    chk("corner_qf0", queried[8'hF0], 0);
    chk("corner_queries", count_queried(), 4);

    // Grant held off for 20 cycles; a start during the stall is ignored.
    clear_board(4'd3);
    gnt = 1'b0;
    kick(8'h33);
    n = 0;
    while (!rv_wr_req && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("stall_req_seen", rv_wr_req, 1);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      start     = (i == 5);
      seed_addr = 8'h77;
      if (!(rv_wr_req === 1'b1 && rv_wr_addr === 8'h33 && cells_revealed === 9'd0 && busy === 1'b1)) bad++;
    end
    start = 1'b0;
    chk("stall_stable_bad_cycles", bad, 0);
    gnt = 1'b1;
    wait_done(50, cyc, to);
    repeat (3) @(negedge clk);
    chk("stall_timeout", to, 0);
    chk("stall_writes", total_writes, 1);
    chk("stall_wr_33", wr_count[8'h33], 1);
    chk("stall_wr_77", wr_count[8'h77], 0);
    chk("stall_count", cells_revealed, 1);
    chk("stall_busy_after", busy, 0);

    // Abort mid-fill with a non-empty queue, then a clean fill from 0x10.
    clear_board(4'd0);
    kick(8'h88);
    n = 0;
    while (cells_revealed < 9'd10 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("abort_pre_progress", (cells_revealed >= 9'd10) ? 1 : 0, 1);
    chk("abort_pre_fifo_empty", dut.u_fifo.empty, 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_req", rv_wr_req, 0);
    chk("abort_fifo_empty", dut.u_fifo.empty, 1);
    repeat (5) @(negedge clk);
    chk("abort_no_done", done_cnt, 0);
    clear_board(4'd0);
    kick(8'h10);
    wait_done(7000, cyc, to);
    @(negedge clk);
    chk("refill_timeout", to, 0);
    chk("refill_writes", total_writes, 256);
    chk("refill_once", count_once(), 256);
    chk("refill_count", cells_revealed, 256);
    chk("refill_done_pulses", done_cnt, 1);

    // Seed already revealed: done with no write.
    clear_board(4'd0);
    rev[8'h40] = 1'b1;
    kick(8'h40);
    wait_done(50, cyc, to);
    @(negedge clk);
    chk("rev_timeout", to, 0);
    chk("rev_writes", total_writes, 0);
    chk("rev_count", cells_revealed, 0);
    chk("rev_done_pulses", done_cnt, 1);

    // Flagged zero-adjacency neighbour 0x11 is skipped.
    clear_board(4'd0);
    flag[8'h11] = 1'b1;
    kick(8'h00);
    wait_done(7000, cyc, to);
    @(negedge clk);
    chk("flag_timeout", to, 0);
    chk("flag_wr_11", wr_count[8'h11], 0);
    chk("flag_writes", total_writes, 255);
    chk("flag_count", cells_revealed, 255);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
